// File: rtl/mtpsa_digest_extract.sv
// mtpsa_digest_extract: forwards the switch-wrapper packet stream through a
// one-deep register slice, narrowing tuser to the 40-bit metadata, and queues
// {src_port, digest} of flagged packets in a small FIFO for the CPU/DMA path.
// Build option: define MTPSA_DIGEST_CLEAR_FLAG_EN to force forwarded
// tuser[32] (send_dig_to_cpu) to 0 so later stages do not re-send the digest.
module mtpsa_digest_extract #(
  parameter int C_AXIS_DATA_WIDTH   = 256,
  parameter int META_WIDTH          = 40,
  parameter int DIGEST_WIDTH        = 256,
  parameter int DIG_FIFO_DEPTH_LOG2 = 2
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic [DIGEST_WIDTH+META_WIDTH-1:0]   s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic [META_WIDTH-1:0]                m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [DIGEST_WIDTH+8-1:0]            m_dig_tdata,
  output logic                                 m_dig_tvalid,
  input  logic                                 m_dig_tready,
  output logic [31:0]                          dig_drop_cnt
);

  localparam int KEEP_WIDTH  = C_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_WIDTH = DIGEST_WIDTH + 8;
  localparam int PW          = DIG_FIFO_DEPTH_LOG2;
  localparam int DEPTH       = 2 ** PW;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  // Packet slice registers
  logic [C_AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]        tkeep_q, tkeep_d;
  logic [META_WIDTH-1:0]        tuser_q, tuser_d;
  logic                         tlast_q, tlast_d;
  logic                         tvalid_q, tvalid_d;
  logic                         sop_q, sop_d;

  // Digest FIFO state
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [PW:0]                  count_q, count_d;
  logic [31:0]                  drop_cnt_q, drop_cnt_d;
  logic [ENTRY_WIDTH-1:0]       mem_q [DEPTH];

  logic                         accept, push, pop, full, do_write, do_drop;
  logic [META_WIDTH-1:0]        meta_fwd;
  logic [ENTRY_WIDTH-1:0]       push_entry;

  assign s_axis_tready = !tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign full          = (count_q == FULL_CNT);
  // Popping an empty FIFO is a no-op, so pop is qualified by non-empty.
  assign pop           = (count_q != '0) && m_dig_tready;
  assign push          = accept && sop_q && s_axis_tuser[32];
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_write      = push && (!full || pop);
  assign do_drop       = push && full && !pop;
  assign push_entry    = {s_axis_tuser[23:16], s_axis_tuser[META_WIDTH +: DIGEST_WIDTH]};

`ifdef MTPSA_DIGEST_CLEAR_FLAG_EN
  // Forwarded metadata with the send-digest flag cleared
  always_comb begin
    meta_fwd     = s_axis_tuser[META_WIDTH-1:0];
    meta_fwd[32] = 1'b0;
  end
`else
  assign meta_fwd = s_axis_tuser[META_WIDTH-1:0];
`endif

  // Next-state for the packet slice, SOP tracker and FIFO bookkeeping
  always_comb begin
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tuser_d    = tuser_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    sop_d      = sop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;

    if (accept) begin
      tdata_d  = s_axis_tdata;
      tkeep_d  = s_axis_tkeep;
      tuser_d  = meta_fwd;
      tlast_d  = s_axis_tlast;
      tvalid_d = 1'b1;
      sop_d    = s_axis_tlast;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    if (do_write) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);

    case ({do_write, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (do_drop && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // State registers; reset discards any in-flight beat and queued digests
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tuser_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      sop_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      sop_q      <= sop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage, one register per entry; cleared on reset so the head reads 0
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst) begin
        mem_q[gi] <= '0;
      end else if (do_write && (wr_ptr_q == PW'(gi))) begin
        mem_q[gi] <= push_entry;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_dig_tvalid  = (count_q != '0);
  assign m_dig_tdata   = mem_q[rd_ptr_q];
  assign dig_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mtpsa_digest_extract.sv
// Self-checking bench for mtpsa_digest_extract: queue-based reference model
// of the packet slice and digest FIFO, directed table vectors and random traffic.
module tb_mtpsa_digest_extract;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int MW = 40;
  localparam int GW = 256;
  localparam int EW = GW + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0]    s_axis_tdata = '0;
  logic [KW-1:0]    s_axis_tkeep = '0;
  logic [GW+MW-1:0] s_axis_tuser = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic             s_axis_tlast = 1'b0;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic [MW-1:0]    m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic             m_axis_tlast;
  logic [EW-1:0]    m_dig_tdata;
  logic             m_dig_tvalid;
  logic             m_dig_tready = 1'b0;
  logic [31:0]      dig_drop_cnt;

  always #5 clk = ~clk;

  mtpsa_digest_extract dut (
    .axis_aclk     (clk),
    .axis_rst      (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_dig_tdata   (m_dig_tdata),
    .m_dig_tvalid  (m_dig_tvalid),
    .m_dig_tready  (m_dig_tready),
    .dig_drop_cnt  (dig_drop_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [MW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [7:0]  dig;
    logic        flag;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_drop;
  } vec_t;

  // Reference model state
  beat_t         exp_q[$];
  logic [EW-1:0] dq[$];
  logic          msop = 1'b1;
  logic [31:0]   mdrop = '0;
  beat_t         mon_e;
  bit            rand_rdy = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] exp_meta(input logic [MW-1:0] u);
    logic [MW-1:0] r;
    r = u;
`ifdef MTPSA_DIGEST_CLEAR_FLAG_EN
    r[32] = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [GW+MW-1:0] mk_user(input logic [GW-1:0] dig, input logic flag,
                                               input logic [7:0] src);
    return {dig, 7'h00, flag, 8'h5A, src, 16'd64};
  endfunction

  // Monitor: compare outputs against the model, then advance the model by
  // the handshakes that complete at the coming rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_tvalid_occupancy", m_axis_tvalid, exp_q.size() != 0);
      chk("s_tready_rule", s_axis_tready, !m_axis_tvalid || m_axis_tready);
      chk("dig_tvalid", m_dig_tvalid, dq.size() != 0);
      chk("drop_cnt", dig_drop_cnt, mdrop);
      if (dq.size() != 0) chk("dig_tdata", m_dig_tdata, dq[0]);
      if (m_axis_tvalid && m_axis_tready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("m_tdata", m_axis_tdata, mon_e.data);
        chk("m_tkeep", m_axis_tkeep, mon_e.keep);
        chk("m_tuser", m_axis_tuser, mon_e.user);
        chk("m_tlast", m_axis_tlast, mon_e.last);
      end
      if (m_dig_tvalid && m_dig_tready && dq.size() != 0) void'(dq.pop_front());
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back('{s_axis_tdata, s_axis_tkeep, exp_meta(s_axis_tuser[MW-1:0]), s_axis_tlast});
        if (msop && s_axis_tuser[32]) begin
          if (dq.size() < 4) dq.push_back({s_axis_tuser[23:16], s_axis_tuser[MW +: GW]});
          else if (mdrop != 32'hFFFF_FFFF) mdrop++;
        end
        msop = s_axis_tlast;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_clear();
    exp_q.delete();
    dq.delete();
    msop  = 1'b1;
    mdrop = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    model_clear();
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [GW+MW-1:0] u, input logic l);
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      if (rand_rdy) begin
        m_axis_tready = 1'($urandom_range(0, 1));
        m_dig_tready  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (s_axis_tready) begin
        tick();
        break;
      end
      tick();
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got=stalled exp=accepted");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    logic [GW+MW-1:0] u;
    logic [GW-1:0]    dg;
    logic [7:0]       src;
    int               len;

    for (int i = 0; i < 6; i++) begin
      tbl[i].dig       = 8'(i + 1);
      tbl[i].flag      = 1'b1;
      tbl[i].rdy       = 1'b0;
      tbl[i].exp_valid = 1'b1;
      tbl[i].exp_drop  = (i + 1 > 4) ? 32'(i + 1 - 4) : 32'd0;
    end
    tbl[6] = '{8'd7, 1'b0, 1'b0, 1'b1, 32'd2};

    // Reset state
    idle(2);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_m_tkeep", m_axis_tkeep, '0);
    chk("rst_m_tuser", m_axis_tuser, '0);
    chk("rst_m_tlast", m_axis_tlast, 1'b0);
    chk("rst_dig_tvalid", m_dig_tvalid, 1'b0);
    chk("rst_dig_tdata", m_dig_tdata, '0);
    chk("rst_drop_cnt", dig_drop_cnt, '0);
    chk("rst_s_tready", s_axis_tready, 1'b1);
    model_clear();
    rst = 1'b0;
    tick();

    // 3-beat flagged packet, src 0x04, digest A5..A5
    m_axis_tready = 1'b1;
    m_dig_tready  = 1'b0;
    u = mk_user({32{8'hA5}}, 1'b1, 8'h04);
    send_beat(rnd_data(), '1, u, 1'b0);
    send_beat(rnd_data(), '1, u, 1'b0);
    send_beat(rnd_data(), 32'h0000_FFFF, u, 1'b1);
    idle(2);
    chk("t1_dig_valid", m_dig_tvalid, 1'b1);
    chk("t1_dig_data", m_dig_tdata, {8'h04, {32{8'hA5}}});
    chk("t1_drop", dig_drop_cnt, 32'd0);
    m_dig_tready = 1'b1;
    tick();
    m_dig_tready = 1'b0;
    chk("t1_dig_popped", m_dig_tvalid, 1'b0);

    // Flag only on a later beat: nothing pushed
    send_beat(rnd_data(), '1, mk_user({32{8'h3C}}, 1'b0, 8'h02), 1'b0);
    send_beat(rnd_data(), '1, mk_user({32{8'h3C}}, 1'b0, 8'h02), 1'b0);
    send_beat(rnd_data(), '1, mk_user({32{8'h3C}}, 1'b1, 8'h02), 1'b1);
    idle(2);
    chk("t2_no_push", m_dig_tvalid, 1'b0);

    // Overflow table: 6 flagged single-beat packets into a 4-entry FIFO
    do_reset();
    for (int i = 0; i < 7; i++) begin
      m_dig_tready = tbl[i].rdy;
      send_beat(rnd_data(), '1, mk_user(GW'(tbl[i].dig), tbl[i].flag, 8'(8'h10 + i)), 1'b1);
      idle(1);
      chk("tbl_dig_valid", m_dig_tvalid, tbl[i].exp_valid);
      chk("tbl_drop", dig_drop_cnt, tbl[i].exp_drop);
    end
    m_dig_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", m_dig_tvalid, 1'b1);
      chk("drain_order", m_dig_tdata, {8'(8'h10 + i), GW'(i + 1)});
      tick();
    end
    m_dig_tready = 1'b0;
    chk("drain_empty", m_dig_tvalid, 1'b0);

    // Full FIFO with pop in the same cycle as a flagged SOP push
    for (int i = 0; i < 4; i++)
      send_beat(rnd_data(), '1, mk_user(GW'(8'h11 + i), 1'b1, 8'h20), 1'b1);
    m_dig_tready = 1'b1;
    send_beat(rnd_data(), '1, mk_user(GW'(8'h15), 1'b1, 8'h21), 1'b1);
    m_dig_tready = 1'b0;
    chk("fullpop_drop", dig_drop_cnt, 32'd2);
    m_dig_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("fullpop_order", m_dig_tdata, {8'h20, GW'(8'h12 + i)});
      tick();
    end
    chk("fullpop_last", m_dig_tdata, {8'h21, GW'(8'h15)});
    tick();
    m_dig_tready = 1'b0;
    chk("fullpop_count4", m_dig_tvalid, 1'b0);

    // Toggling downstream ready across a 4-beat packet
    m_axis_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          m_axis_tready = ~m_axis_tready;
          tick();
        end
        m_axis_tready = 1'b1;
      end
      begin
        for (int i = 0; i < 4; i++)
          send_beat(rnd_data(), '1, mk_user(GW'(8'h99), 1'b0, 8'h07), i == 3);
      end
    join
    idle(3);
    chk("toggle_drained", m_axis_tvalid, 1'b0);

    // Reset mid-packet with two queued digests
    do_reset();
    m_dig_tready = 1'b0;
    send_beat(rnd_data(), '1, mk_user(GW'(8'h41), 1'b1, 8'h01), 1'b1);
    send_beat(rnd_data(), '1, mk_user(GW'(8'h42), 1'b1, 8'h01), 1'b1);
    send_beat(rnd_data(), '1, mk_user(GW'(8'h43), 1'b0, 8'h01), 1'b0);
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("mrst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("mrst_m_tdata", m_axis_tdata, '0);
    chk("mrst_m_tuser", m_axis_tuser, '0);
    chk("mrst_m_tlast", m_axis_tlast, 1'b0);
    chk("mrst_dig_tvalid", m_dig_tvalid, 1'b0);
    chk("mrst_dig_tdata", m_dig_tdata, '0);
    chk("mrst_drop", dig_drop_cnt, '0);
    tick();
    rst = 1'b0;
    tick();
    send_beat(rnd_data(), '1, mk_user(GW'(8'h77), 1'b1, 8'h33), 1'b0);
    chk("mrst_sop_push_valid", m_dig_tvalid, 1'b1);
    chk("mrst_sop_push_data", m_dig_tdata, {8'h33, GW'(8'h77)});
    send_beat(rnd_data(), '1, mk_user(GW'(8'h78), 1'b1, 8'h33), 1'b1);
    idle(2);

    // Random traffic with random back-pressure on both outputs
    do_reset();
    rand_rdy = 1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 4);
      src = 8'($urandom);
      dg  = rnd_data();
      for (int b = 0; b < len; b++) begin
        u = {dg, 7'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), src, 16'($urandom)};
        send_beat(rnd_data(), KW'($urandom), u, b == len - 1);
      end
    end
    rand_rdy = 0;
    m_axis_tready = 1'b1;
    m_dig_tready  = 1'b1;
    idle(10);
    chk("rand_pkt_drained", m_axis_tvalid, 1'b0);
    chk("rand_dig_drained", m_dig_tvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtpsa_digest_extract.md
Name: mtpsa_digest_extract

Overview:
Downstream stage of the user SDNet switch wrapper. Consumes its packet stream, whose wide tuser carries {digest, 40-bit metadata}. Forwards packets unchanged with only the 40-bit metadata as tuser. On the first beat of any packet with send_dig_to_cpu set, captures the digest plus src_port into a small FIFO and presents it on a separate single-beat AXI-Stream toward the DMA/CPU path.

Parameters:
C_AXIS_DATA_WIDTH, 256, packet tdata width; tkeep is C_AXIS_DATA_WIDTH/8.
META_WIDTH, 40, metadata tuser width: [15:0] pkt_len, [23:16] src_port, [31:24] dst_port, [32] send_dig_to_cpu.
DIGEST_WIDTH, 256, digest field width.
DIG_FIFO_DEPTH_LOG2, 2, digest FIFO depth is 2**DIG_FIFO_DEPTH_LOG2 (default 4 entries).

Ports:
axis_aclk  in  1  sole clock.
axis_rst  in  1  asynchronous, active-high reset.
s_axis_tdata  in  C_AXIS_DATA_WIDTH  packet data from switch wrapper.
s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables.
s_axis_tuser  in  DIGEST_WIDTH+META_WIDTH  {digest, metadata}, metadata in LSBs.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
s_axis_tlast  in  1  end of packet.
m_axis_tdata  out  C_AXIS_DATA_WIDTH  forwarded data.
m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  forwarded byte enables.
m_axis_tuser  out  META_WIDTH  forwarded metadata, unmodified.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
m_axis_tlast  out  1  forwarded end of packet.
m_dig_tdata  out  DIGEST_WIDTH+8  {src_port, digest} of the head FIFO entry.
m_dig_tvalid  out  1  FIFO non-empty.
m_dig_tready  in  1  digest consumer ready; the entry pops on tvalid&tready.
dig_drop_cnt  out  32  digests lost to a full FIFO; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, FIFO empty (m_dig_tvalid=0, m_dig_tdata=0), dig_drop_cnt=0, sop=1. Reset mid-packet discards the in-flight beat and FIFO contents. The first beat after reset is treated as SOP.
- Packet path is a single register slice:
  - s_axis_tready = !m_axis_tvalid | m_axis_tready (combinational).
  - Accept = s_axis_tvalid & s_axis_tready. Latency is 1 cycle, with full throughput under continuous ready.
  - The output register loads on accept. m_axis_tvalid clears when the output handshakes without a new accept.
  - Data/keep/last/tuser[META_WIDTH-1:0] pass through bit-exact.
- SOP tracking: sop is set by accepting a beat with tlast=1 and cleared by accepting a beat with tlast=0. A single-beat packet leaves sop=1.
- Digest push: on accept with sop=1 and s_axis_tuser[32]=1, push {s_axis_tuser[23:16], s_axis_tuser[META_WIDTH+:DIGEST_WIDTH]}. Later beats of the packet never push.
- The packet path never stalls on the digest path; pushes happen independently of m_dig_tready.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of DIG_FIFO_DEPTH_LOG2 bits (natural wrap) and count of DIG_FIFO_DEPTH_LOG2+1 bits.
  - m_dig_tvalid = (count!=0). m_dig_tdata = mem[rd_ptr].
  - Push with count==DEPTH and no pop in the same cycle: digest dropped, dig_drop_cnt += 1 (saturating), packet still forwarded.
  - Push and pop in the same cycle at full: push accepted, count unchanged.
  - Simultaneous push and pop at any level: count unchanged.
  - Pop when empty is ignored.
- m_dig_tdata holds steady while tvalid=1 and tready=0.

Optional Feature:
MTPSA_DIGEST_CLEAR_FLAG_EN: when defined, forwarded m_axis_tuser[32] is forced to 0 on every beat, so downstream output queues do not re-send the digest. When undefined, tuser passes through unmodified. Digest capture is identical in both builds.

Test Plan:
- Reset, then one 3-beat packet with tuser[32]=1, src_port=0x04, digest=0xA5..A5, ready always 1 -> m_axis beats appear 1 cycle after input, bit-exact. One digest entry m_dig_tdata={0x04, 0xA5..A5}. dig_drop_cnt=0.
- Packet with tuser[32]=0 on beat 0 and bit 32=1 on beat 2 -> no digest pushed, m_dig_tvalid stays 0.
- m_dig_tready=0; send 6 single-beat packets with flag set and digests 1..6 -> FIFO holds digests 1..4, dig_drop_cnt=2, all 6 packets forwarded. Then tready=1 -> digests 1,2,3,4 in order.
- FIFO full and m_dig_tready=1 while a flagged SOP is accepted in the same cycle -> no drop, count stays 4, new digest appears last.
- m_axis_tready toggles 1010... across a 4-beat packet -> s_axis_tready follows the rule, no beat lost or duplicated, tlast on beat 4 only.
- Assert axis_rst mid-packet with 2 FIFO entries -> all outputs 0 immediately. The next beat is treated as SOP and pushes its digest if flagged.
